dot_acc_seq: RTL and testbench

- Streaming dot-product sequencer wrapped around the registered 8x8 array multiplier.
- Upstream side: accepts operand pairs on a valid/ready stream and drives the multiplier's operand buses and load enables.
- Downstream side: consumes the multiplier's registered product, accumulates one packet (terminated by in_last), and emits the sum on a valid/ready result stream.
- The multiplier is instantiated beside this block, not inside it.

---
 rtl/dot_acc_pkg.sv | 15 +
 rtl/dot_acc_seq_if.sv | 38 +++
 rtl/dot_acc_vpipe.sv | 35 +++
 rtl/dot_acc_seq.sv | 104 ++++++++++
 tb/tb_dot_acc_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dot_acc_pkg.sv
// Shared types and default widths for the dot-product sequencer family.
package dot_acc_pkg;

    localparam int N_DEF     = 8;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;
    localparam int LAT_DEF   = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dot_acc_seq_if.sv
// Operand stream, multiplier side-channel and result stream of the sequencer.
interface dot_acc_seq_if
    import dot_acc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_last;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic             mul_ea;
    logic             mul_eb;
    logic [2*N-1:0]   mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, mul_ea, mul_eb,
        input  out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_p, out_ready,
        output in_ready, mul_a, mul_b, mul_ea, mul_eb,
        output out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/dot_acc_vpipe.sv
// Valid+last tag pipe that tracks beats through the external multiplier.
// Latency: LAT edges from in_vld to out_vld.
// Backpressure: none; it always shifts, reset drops every in-flight tag.
module dot_acc_vpipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  logic in_last,
    output logic out_vld,
    output logic out_last
);

    logic [LAT-1:0] vld_sr;
    logic [LAT-1:0] last_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= in_vld;
            last_sr[0] <= in_vld & in_last;
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign out_vld  = vld_sr[LAT-1];
    assign out_last = last_sr[LAT-1];

endmodule

// File: rtl/dot_acc_seq.sv
// Streaming dot-product sequencer: feeds an external registered multiplier, sums one packet.
// Latency: last beat accepted at edge k gives out_valid after edge k+LAT.
// Backpressure: in_ready drops from last-beat accept until the result handshake completes.
module dot_acc_seq
    import dot_acc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LAT   = LAT_DEF
) (
    input logic         clk,
    input logic         rst,
    dot_acc_seq_if.slave bus
);

    localparam int SUM_W = ACC_W + 1;

    state_t           state, state_nxt;
    logic             accept;
    logic             pipe_vld, pipe_last;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [SUM_W-1:0] sum_ext;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;

    assign bus.in_ready = (state == RUN);
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.mul_a    = bus.in_a;
    assign bus.mul_b    = bus.in_b;
    assign bus.mul_ea   = accept;
    assign bus.mul_eb   = accept;

    dot_acc_vpipe #(.LAT(LAT)) u_vpipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (accept),
        .in_last  (bus.in_last),
        .out_vld  (pipe_vld),
        .out_last (pipe_last)
    );

    // Top bit of the widened sum is the carry out of the accumulator.
    assign sum_ext = {1'b0, acc} + SUM_W'(bus.mul_p);

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (accept && bus.in_last)           state_nxt = DRAIN;
            DRAIN:   if (pipe_vld && pipe_last)           state_nxt = DONE;
            DONE:    if (out_valid_q && bus.out_ready)    state_nxt = RUN;
            default:                                      state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (pipe_vld) begin
                if (pipe_last) begin
                    out_sum_q   <= sum_ext[ACC_W-1:0];
                    out_count_q <= cnt + 1'b1;
                    out_ovf_q   <= ovf | sum_ext[ACC_W];
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                end else begin
                    acc <= sum_ext[ACC_W-1:0];
                    cnt <= cnt + 1'b1;
                    ovf <= ovf | sum_ext[ACC_W];
                end
            end
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_acc_seq.sv
// Directed bench: two sequencers (24-bit and 16-bit accumulators) with behavioural multipliers.
module tb_dot_acc_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    dot_acc_seq_if #(.N(8), .ACC_W(24), .CNT_W(8)) ifa ();
    dot_acc_seq_if #(.N(8), .ACC_W(16), .CNT_W(8)) ifb ();

    dot_acc_seq #(.N(8), .ACC_W(24), .CNT_W(8), .LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dot_acc_seq #(.N(8), .ACC_W(16), .CNT_W(8), .LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Registered multipliers: operands latch at edge k, product register at edge k+1.
    logic [7:0] a_ra, b_ra, a_rb, b_rb;
    always @(posedge clk) begin
        if (ifa.mul_ea) a_ra <= ifa.mul_a;
        if (ifa.mul_eb) b_ra <= ifa.mul_b;
        ifa.mul_p <= 16'(a_ra) * 16'(b_ra);
        if (ifb.mul_ea) a_rb <= ifb.mul_a;
        if (ifb.mul_eb) b_rb <= ifb.mul_b;
        ifb.mul_p <= 16'(a_rb) * 16'(b_rb);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat on ifa and returns #1 after the edge that accepted it.
    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        ifa.in_valid = 1'b1;
        ifa.in_a     = a;
        ifa.in_b     = b;
        ifa.in_last  = last;
        n = 0;
        while (!ifa.in_ready && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!ifa.in_ready) begin
            fails++;
            $display("FAIL put_accept_timeout: in_ready=%0b after %0d cycles, required 1", ifa.in_ready, n);
        end
        step();
    endtask

    task automatic wait_out(input bit sel_b, output int cyc);
        cyc = 0;
        while (!(sel_b ? ifb.out_valid : ifa.out_valid) && cyc < 30) begin
            step();
            cyc++;
        end
    endtask

    task automatic handshake_a();
        ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b, required 0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b, required 1", ifa.in_ready); end
        checks++; if (ifa.out_sum !== 24'd0) begin fails++; $display("FAIL reset_out_sum: got %0d, required 0", ifa.out_sum); end
        checks++; if (ifa.out_count !== 8'd0) begin fails++; $display("FAIL reset_out_count: got %0d, required 0", ifa.out_count); end
        checks++; if (ifa.out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf: got %0b, required 0", ifa.out_ovf); end
        checks++; if (ifa.mul_ea !== 1'b0) begin fails++; $display("FAIL reset_mul_ea: got %0b, required 0", ifa.mul_ea); end
        checks++; if (ifb.in_ready !== 1'b1) begin fails++; $display("FAIL reset_b_in_ready: got %0b, required 1", ifb.in_ready); end
    endtask

    task automatic test_single();
        put(8'd255, 8'd255, 1'b1);
        ifa.in_valid = 1'b0;
        checks++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL single_in_ready_drain: got %0b, required 0", ifa.in_ready); end
        step();
        checks++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %0b after k+1, required 0", ifa.out_valid); end
        step();
        checks++; if (ifa.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid_k2: got %0b after k+2, required 1", ifa.out_valid); end
        checks++; if (ifa.out_sum !== 24'd65025) begin fails++; $display("FAIL single_sum: got %0d, required 65025", ifa.out_sum); end
        checks++; if (ifa.out_count !== 8'd1) begin fails++; $display("FAIL single_count: got %0d, required 1", ifa.out_count); end
        checks++; if (ifa.out_ovf !== 1'b0) begin fails++; $display("FAIL single_ovf: got %0b, required 0", ifa.out_ovf); end
        handshake_a();
        checks++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_clear: got %0b, required 0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL single_ready_back: got %0b, required 1", ifa.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
        logic [7:0] bv [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            put(av[i], bv[i], i == 3);
            if (i < 3) begin
                checks++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_beat%0d: got %0b, required 1", i, ifa.in_ready); end
            end
        end
        ifa.in_valid = 1'b0;
        checks++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_after_last: got %0b, required 0", ifa.in_ready); end
        wait_out(1'b0, cyc);
        checks++; if (cyc != 2) begin fails++; $display("FAIL b2b_latency: got %0d cycles, required 2", cyc); end
        checks++; if (ifa.out_sum !== 24'd100) begin fails++; $display("FAIL b2b_sum: got %0d, required 100", ifa.out_sum); end
        checks++; if (ifa.out_count !== 8'd4) begin fails++; $display("FAIL b2b_count: got %0d, required 4", ifa.out_count); end
        checks++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_done: got %0b, required 0", ifa.in_ready); end
        handshake_a();
        checks++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_back: got %0b, required 1", ifa.in_ready); end
    endtask

    task automatic test_ovf16();
        int cyc;
        ifb.in_valid = 1'b1; ifb.in_a = 8'd255; ifb.in_b = 8'd255; ifb.in_last = 1'b0;
        step();
        ifb.in_last = 1'b1;
        step();
        ifb.in_valid = 1'b0;
        wait_out(1'b1, cyc);
        checks++; if (ifb.out_valid !== 1'b1) begin fails++; $display("FAIL ovf16_valid: got %0b after %0d cycles, required 1", ifb.out_valid, cyc); end
        checks++; if (ifb.out_sum !== 16'd64514) begin fails++; $display("FAIL ovf16_sum: got %0d, required 64514", ifb.out_sum); end
        checks++; if (ifb.out_ovf !== 1'b1) begin fails++; $display("FAIL ovf16_flag: got %0b, required 1", ifb.out_ovf); end
        checks++; if (ifb.out_count !== 8'd2) begin fails++; $display("FAIL ovf16_count: got %0d, required 2", ifb.out_count); end
        ifb.out_ready = 1'b1;
        step();
        ifb.out_ready = 1'b0;
        ifb.in_valid = 1'b1; ifb.in_a = 8'd2; ifb.in_b = 8'd3; ifb.in_last = 1'b1;
        step();
        ifb.in_valid = 1'b0;
        wait_out(1'b1, cyc);
        checks++; if (ifb.out_sum !== 16'd6) begin fails++; $display("FAIL ovf16_next_sum: got %0d, required 6", ifb.out_sum); end
        checks++; if (ifb.out_ovf !== 1'b0) begin fails++; $display("FAIL ovf16_next_flag: got %0b, required 0", ifb.out_ovf); end
        ifb.out_ready = 1'b1;
        step();
        ifb.out_ready = 1'b0;
    endtask

    task automatic test_gaps();
        logic [7:0] av [3] = '{8'd10, 8'd20, 8'd0};
        logic [7:0] bv [3] = '{8'd10, 8'd5, 8'd255};
        int         gap [3] = '{2, 0, 3};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b0;
            repeat (gap[i]) step();
            put(av[i], bv[i], i == 2);
        end
        ifa.in_valid = 1'b0;
        wait_out(1'b0, cyc);
        checks++; if (ifa.out_sum !== 24'd200) begin fails++; $display("FAIL gaps_sum: got %0d, required 200", ifa.out_sum); end
        checks++; if (ifa.out_count !== 8'd3) begin fails++; $display("FAIL gaps_count: got %0d, required 3", ifa.out_count); end
        handshake_a();
    endtask

    task automatic test_stall();
        int cyc;
        put(8'd4, 8'd5, 1'b1);
        ifa.in_valid = 1'b0;
        wait_out(1'b0, cyc);
        ifa.in_valid = 1'b1; ifa.in_a = 8'd6; ifa.in_b = 8'd7; ifa.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ifa.out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid_c%0d: got %0b, required 1", i, ifa.out_valid); end
            checks++; if (ifa.out_sum !== 24'd20) begin fails++; $display("FAIL stall_sum_c%0d: got %0d, required 20", i, ifa.out_sum); end
            checks++; if (ifa.out_count !== 8'd1) begin fails++; $display("FAIL stall_count_c%0d: got %0d, required 1", i, ifa.out_count); end
            checks++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready_c%0d: got %0b, required 0", i, ifa.in_ready); end
            checks++; if ({ifa.mul_ea, ifa.mul_eb} !== 2'b00) begin fails++; $display("FAIL stall_enables_c%0d: got %b, required 00", i, {ifa.mul_ea, ifa.mul_eb}); end
            step();
        end
        handshake_a();
        checks++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL stall_valid_clear: got %0b, required 0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL stall_ready_back: got %0b, required 1", ifa.in_ready); end
        checks++; if (ifa.mul_ea !== 1'b1) begin fails++; $display("FAIL stall_mul_ea_back: got %0b, required 1", ifa.mul_ea); end
        step();
        ifa.in_valid = 1'b0;
        wait_out(1'b0, cyc);
        checks++; if (cyc != 2) begin fails++; $display("FAIL stall_next_latency: got %0d cycles, required 2", cyc); end
        checks++; if (ifa.out_sum !== 24'd42) begin fails++; $display("FAIL stall_next_sum: got %0d, required 42", ifa.out_sum); end
        handshake_a();
    endtask

    task automatic test_mid_reset();
        int cyc;
        put(8'd9, 8'd9, 1'b0);
        put(8'd8, 8'd8, 1'b0);
        ifa.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b, required 0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b, required 1", ifa.in_ready); end
        put(8'd3, 8'd3, 1'b1);
        ifa.in_valid = 1'b0;
        wait_out(1'b0, cyc);
        checks++; if (ifa.out_sum !== 24'd9) begin fails++; $display("FAIL rst_next_sum: got %0d, required 9", ifa.out_sum); end
        checks++; if (ifa.out_count !== 8'd1) begin fails++; $display("FAIL rst_next_count: got %0d, required 1", ifa.out_count); end
        checks++; if (ifa.out_ovf !== 1'b0) begin fails++; $display("FAIL rst_next_ovf: got %0b, required 0", ifa.out_ovf); end
        handshake_a();
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.in_b = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.in_b = '0; ifb.in_last = 1'b0; ifb.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ovf16();
        test_gaps();
        test_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
